// File: rtl/yuv422_stream_source.sv
// yuv422_stream_source: frame-timing and test-pattern generator producing a
// YUV422 stream (vsync/de/y/c) for the scalers' per_img input.
//
// Ports:
//   clk_in1        pixel clock
//   rst_n          synchronous active-low reset
//   enable         frame-run request (sampled in S_IDLE and at the end of S_VGAP)
//   img_width      active pixels per line (even, 2..2047)
//   img_height     active lines per frame (1..2047)
//   pattern_sel    test-pattern select (0..3)
//   post_img_vsync frame valid
//   post_img_de    pixel valid
//   post_img_y     luma
//   post_img_c     chroma, Cb on even x and Cr on odd x
//   frame_done     one-cycle pulse on the first vertical-gap cycle
module yuv422_stream_source #(
  parameter int unsigned C_VS_FRONT = 8,
  parameter int unsigned C_HBLANK   = 32,
  parameter int unsigned C_VS_BACK  = 8,
  parameter int unsigned C_VGAP     = 16
) (
  input  logic        clk_in1,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [10:0] img_width,
  input  logic [10:0] img_height,
  input  logic [1:0]  pattern_sel,
  output logic        post_img_vsync,
  output logic        post_img_de,
  output logic [7:0]  post_img_y,
  output logic [7:0]  post_img_c,
  output logic        frame_done
);

  localparam int unsigned CNT_W  = 11;
  localparam int unsigned MAX_FB = (C_VS_FRONT > C_VS_BACK) ? C_VS_FRONT : C_VS_BACK;
  localparam int unsigned MAX_HG = (C_HBLANK > C_VGAP) ? C_HBLANK : C_VGAP;
  localparam int unsigned PH_MAX = (MAX_FB > MAX_HG) ? MAX_FB : MAX_HG;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] PH_FRONT_END = PH_W'(C_VS_FRONT - 1);
  localparam logic [PH_W-1:0] PH_HBL_END   = PH_W'(C_HBLANK - 1);
  localparam logic [PH_W-1:0] PH_BACK_END  = PH_W'(C_VS_BACK - 1);
  localparam logic [PH_W-1:0] PH_VGAP_END  = PH_W'(C_VGAP - 1);

  localparam logic [7:0] Y_BLANK = 8'h10;
  localparam logic [7:0] C_BLANK = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VS_FRONT,
    S_LINE,
    S_HBLANK,
    S_VS_BACK,
    S_VGAP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] x_cnt, x_nxt;
  logic [CNT_W-1:0] y_cnt, y_nxt;
  logic [PH_W-1:0]  ph_cnt, ph_nxt;
  logic [CNT_W-1:0] shadow_width, shadow_height;
  logic [1:0]       shadow_pattern;
  logic             latch_c;
  logic             vsync_c, de_c, frame_done_c;
  logic [15:0]      pix_c;

  // Test-pattern pixel {y, c} for a given position.
  function automatic logic [15:0] pixel(input logic [1:0] p,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
    logic [15:0] r;
    case (p)
      2'd0:    r = {x, C_BLANK};
      2'd1:    r = {y, C_BLANK};
      2'd2:    r = {((x[4] ^ y[4]) ? 8'hEB : 8'h10), C_BLANK};
      default: r = {8'(x + y), (x[0] ? 8'hC0 : 8'h40)};
    endcase
    return r;
  endfunction

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    x_nxt     = x_cnt;
    y_nxt     = y_cnt;
    ph_nxt    = ph_cnt;
    latch_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_VS_FRONT;
          ph_nxt    = '0;
          latch_c   = 1'b1;
        end
      end
      S_VS_FRONT: begin
        if (ph_cnt == PH_FRONT_END) begin
          state_nxt = S_LINE;
          x_nxt     = '0;
          y_nxt     = '0;
          ph_nxt    = '0;
        end else begin
          ph_nxt = ph_cnt + PH_W'(1);
        end
      end
      S_LINE: begin
        if (x_cnt == shadow_width - CNT_W'(1)) begin
          ph_nxt    = '0;
          state_nxt = (y_cnt == shadow_height - CNT_W'(1)) ? S_VS_BACK : S_HBLANK;
        end else begin
          x_nxt = x_cnt + CNT_W'(1);
        end
      end
      S_HBLANK: begin
        if (ph_cnt == PH_HBL_END) begin
          state_nxt = S_LINE;
          x_nxt     = '0;
          y_nxt     = y_cnt + CNT_W'(1);
          ph_nxt    = '0;
        end else begin
          ph_nxt = ph_cnt + PH_W'(1);
        end
      end
      S_VS_BACK: begin
        if (ph_cnt == PH_BACK_END) begin
          state_nxt = S_VGAP;
          ph_nxt    = '0;
        end else begin
          ph_nxt = ph_cnt + PH_W'(1);
        end
      end
      S_VGAP: begin
        if (ph_cnt == PH_VGAP_END) begin
          ph_nxt = '0;
          if (enable) begin
            state_nxt = S_VS_FRONT;
            latch_c   = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          ph_nxt = ph_cnt + PH_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output values derived from the upcoming state so they register alongside it.
  always_comb begin
    vsync_c      = (state_nxt == S_VS_FRONT) || (state_nxt == S_LINE) ||
                   (state_nxt == S_HBLANK)   || (state_nxt == S_VS_BACK);
    de_c         = (state_nxt == S_LINE);
    frame_done_c = (state == S_VS_BACK) && (state_nxt == S_VGAP);
    pix_c        = {Y_BLANK, C_BLANK};
    if (de_c) begin
      pix_c = pixel(shadow_pattern, x_nxt[7:0], y_nxt[7:0]);
    end
  end

  // State, counters, shadows and registered outputs.
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      x_cnt          <= '0;
      y_cnt          <= '0;
      ph_cnt         <= '0;
      shadow_width   <= CNT_W'(2);
      shadow_height  <= CNT_W'(1);
      shadow_pattern <= 2'd0;
      post_img_vsync <= 1'b0;
      post_img_de    <= 1'b0;
      post_img_y     <= Y_BLANK;
      post_img_c     <= C_BLANK;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_nxt;
      x_cnt          <= x_nxt;
      y_cnt          <= y_nxt;
      ph_cnt         <= ph_nxt;
      if (latch_c) begin
        shadow_width   <= img_width;
        shadow_height  <= img_height;
        shadow_pattern <= pattern_sel;
      end
      post_img_vsync <= vsync_c;
      post_img_de    <= de_c;
      post_img_y     <= pix_c[15:8];
      post_img_c     <= pix_c[7:0];
      frame_done     <= frame_done_c;
    end
  end

endmodule
